mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter between the instruction-fetch path (I) and the data-memory path (D) and the single core bus port.
- Serialises whole burst transactions. D has priority by default. A starvation counter guarantees I forward progress, so the pipeline control unit's i_wait cannot be held indefinitely.
- Sits between the fetch/memory stages and the bus interface; i_wait and d_wait are derived from its response ports.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- LEN_W, 4, burst length field; beats = len+1.
- STARVE_MAX, 4, number of consecutive D grants while I is pending that forces the next grant to I.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- i_valid  in  1  I request valid; held until i_last.
- i_addr  in  ADDR_W  I burst start address.
- i_len  in  LEN_W  I burst length (beats-1).
- i_ready  out  1  I beat return valid.
- i_last  out  1  I final beat.
- i_rdata  out  DATA_W  I read data.
- d_valid  in  1  D request valid; held until d_last.
- d_is_write  in  1  D write.
- d_addr  in  ADDR_W  D start address.
- d_len  in  LEN_W  D burst length.
- d_strobe  in  DATA_W/8  D byte enables.
- d_wdata  in  DATA_W  D write data; advances on each d_ready.
- d_ready  out  1  D beat accepted/returned.
- d_last  out  1  D final beat.
- d_rdata  out  DATA_W  D read data.
- o_valid  out  1  bus request valid.
- o_is_write  out  1  bus write.
- o_addr  out  ADDR_W  bus address.
- o_len  out  LEN_W  bus length.
- o_strobe  out  DATA_W/8  bus strobe (0 for I).
- o_wdata  out  DATA_W  bus write data.
- o_ready  in  1  bus beat handshake.
- o_last  in  1  bus final beat.
- o_rdata  in  DATA_W  bus read data.
- proto_err  out  1  sticky protocol error.

Behaviour:
- States: IDLE, GNT_I, GNT_D. Reset (async, resetn=0) forces IDLE, starve_cnt=0, beat_cnt=0, proto_err=0. All outputs are 0 in reset and in IDLE.
- Arbitration in IDLE, registered:
  - d_valid & ~(i_valid & starve_cnt==STARVE_MAX) -> GNT_D.
  - else i_valid -> GNT_I.
  - else stay IDLE.
- Latency: o_valid rises the cycle after the requester's valid is first seen in IDLE.
- GNT_x:
  - o_valid=1 regardless of the master's valid.
  - o_addr, o_len, o_is_write, o_strobe and o_wdata are forwarded combinationally from the granted master.
  - In GNT_I: o_is_write=0, o_strobe=0, o_wdata=0.
  - o_ready/o_last/o_rdata route only to the granted master's ready/last/rdata. The other master sees 0.
- Beat counting:
  - beat_cnt clears on grant and increments on each o_ready.
  - On o_ready&o_last: if beat_cnt != latched len, set proto_err.
  - o_ready without o_last at beat_cnt == len sets proto_err but the burst continues until o_last.
- End of burst (o_ready&o_last), next state chosen by the same rule as IDLE; direct handover with no bubble:
  - other master pending and eligible -> grant it.
  - else same master valid again -> re-grant it.
  - else IDLE.
- Starvation:
  - starve_cnt increments (saturating at STARVE_MAX) on each D grant made while i_valid=1.
  - It clears on any I grant, and on any grant while i_valid=0.
- Master dropping valid mid-burst: a protocol violation. The grant is held until o_last anyway, and proto_err is set.
- Simultaneous first requests in IDLE with starve_cnt<STARVE_MAX: D wins.
- proto_err clears only on reset.

Test Plan:
- Single I read, i_len=3, slave returns 4 beats with o_last on the 4th -> o_valid at cycle+1, i_ready x4, i_last on beat 4, d_ready stays 0, then IDLE.
- Same-cycle i_valid & d_valid, d_is_write=1, d_len=0 -> GNT_D first; o_wdata=d_wdata, o_strobe=d_strobe; after d_last, GNT_I the next cycle with no IDLE bubble.
- d_valid held continuously (len=0) with i_valid=1, STARVE_MAX=4 -> exactly 4 D bursts, then an I burst, then D resumes; starve_cnt returns to 0.
- Slave asserts o_last on beat 2 of a len=3 burst -> proto_err=1 and stays 1; the arbiter still returns to IDLE or the next grant.
- resetn pulled low mid-GNT_D burst -> all outputs 0 immediately (async), state IDLE; after release, a new i_valid is granted normally.
- i_valid dropped mid-burst -> o_valid stays 1 until o_last and proto_err=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester channels (I fetch, D memory) and the shared bus port.
// The slave modport is the arbiter's view; master is the requesters plus the bus slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
);
  logic                  i_valid;
  logic [ADDR_W-1:0]     i_addr;
  logic [LEN_W-1:0]      i_len;
  logic                  i_ready;
  logic                  i_last;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_valid;
  logic                  d_is_write;
  logic [ADDR_W-1:0]     d_addr;
  logic [LEN_W-1:0]      d_len;
  logic [DATA_W/8-1:0]   d_strobe;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_ready;
  logic                  d_last;
  logic [DATA_W-1:0]     d_rdata;

  logic                  o_valid;
  logic                  o_is_write;
  logic [ADDR_W-1:0]     o_addr;
  logic [LEN_W-1:0]      o_len;
  logic [DATA_W/8-1:0]   o_strobe;
  logic [DATA_W-1:0]     o_wdata;
  logic                  o_ready;
  logic                  o_last;
  logic [DATA_W-1:0]     o_rdata;

  modport slave (
    input  i_valid, i_addr, i_len,
    output i_ready, i_last, i_rdata,
    input  d_valid, d_is_write, d_addr, d_len, d_strobe, d_wdata,
    output d_ready, d_last, d_rdata,
    output o_valid, o_is_write, o_addr, o_len, o_strobe, o_wdata,
    input  o_ready, o_last, o_rdata
  );

  modport master (
    output i_valid, i_addr, i_len,
    input  i_ready, i_last, i_rdata,
    output d_valid, d_is_write, d_addr, d_len, d_strobe, d_wdata,
    input  d_ready, d_last, d_rdata,
    input  o_valid, o_is_write, o_addr, o_len, o_strobe, o_wdata,
    output o_ready, o_last, o_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master burst arbiter: I fetch and D memory share one bus port, D preferred,
// with a starvation counter that forces an I grant after STARVE_MAX back-to-back D grants.
//
// state | meaning
// IDLE  | no grant, all bus/response outputs driven 0
// GNT_I | I burst owns the bus until o_ready & o_last
// GNT_D | D burst owns the bus until o_ready & o_last
module mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         resetn,
  mem_arbiter_if.slave bus,
  output logic         proto_err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t            state_q, state_d, pick;
  logic [LEN_W-1:0]  beat_q, len_q, live_len, eff_len;
  logic [SW-1:0]     starve_q;
  logic              fresh_q, granted, burst_end, grant, live_valid, err_set;

  assign granted   = (state_q != IDLE);
  assign burst_end = granted && bus.o_ready && bus.o_last;

  always_comb begin
    pick = IDLE;
    if (bus.d_valid && !(bus.i_valid && starve_q == STARVE_TOP)) pick = GNT_D;
    else if (bus.i_valid) pick = GNT_I;
  end

  // End of burst reuses the idle decision, giving a bubble-free handover.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = pick;
        grant   = (pick != IDLE);
      end
      GNT_I, GNT_D: begin
        if (burst_end) begin
          state_d = pick;
          grant   = (pick != IDLE);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_valid    = 1'b0;
    bus.o_is_write = 1'b0;
    bus.o_addr     = {ADDR_W{1'b0}};
    bus.o_len      = {LEN_W{1'b0}};
    bus.o_strobe   = {(DATA_W/8){1'b0}};
    bus.o_wdata    = {DATA_W{1'b0}};
    bus.i_ready    = 1'b0;
    bus.i_last     = 1'b0;
    bus.i_rdata    = {DATA_W{1'b0}};
    bus.d_ready    = 1'b0;
    bus.d_last     = 1'b0;
    bus.d_rdata    = {DATA_W{1'b0}};
    live_len       = {LEN_W{1'b0}};
    live_valid     = 1'b0;
    case (state_q)
      GNT_I: begin
        bus.o_valid = 1'b1;
        bus.o_addr  = bus.i_addr;
        bus.o_len   = bus.i_len;
        bus.i_ready = bus.o_ready;
        bus.i_last  = bus.o_last;
        bus.i_rdata = bus.o_rdata;
        live_len    = bus.i_len;
        live_valid  = bus.i_valid;
      end
      GNT_D: begin
        bus.o_valid    = 1'b1;
        bus.o_is_write = bus.d_is_write;
        bus.o_addr     = bus.d_addr;
        bus.o_len      = bus.d_len;
        bus.o_strobe   = bus.d_strobe;
        bus.o_wdata    = bus.d_wdata;
        bus.d_ready    = bus.o_ready;
        bus.d_last     = bus.o_last;
        bus.d_rdata    = bus.o_rdata;
        live_len       = bus.d_len;
        live_valid     = bus.d_valid;
      end
      default: ;
    endcase
  end

  // On a back-to-back handover the master still shows the old length in the
  // grant cycle, so the length is captured in the first cycle of the burst.
  assign eff_len = fresh_q ? live_len : len_q;
  assign err_set = granted &&
                   ((bus.o_ready && (bus.o_last != (beat_q == eff_len))) ||
                    (!live_valid && !burst_end));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      len_q     <= '0;
      fresh_q   <= 1'b0;
      starve_q  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      proto_err <= proto_err | err_set;
      if (fresh_q) len_q <= live_len;
      if (grant) begin
        beat_q  <= '0;
        fresh_q <= 1'b1;
        if (state_d == GNT_D && bus.i_valid)
          starve_q <= (starve_q == STARVE_TOP) ? starve_q : starve_q + SW'(1);
        else
          starve_q <= '0;
      end else begin
        fresh_q <= 1'b0;
        if (granted && bus.o_ready) beat_q <= beat_q + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-based requester/slave model with randomized traffic,
// directed starvation, protocol-error and async-reset scenarios.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 4;
  localparam int SM = 4;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [LW-1:0]   len;
    logic            wr;
    logic [DW/8-1:0] strb;
    logic [DW-1:0]   wbase;
  } burst_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic proto_err;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .proto_err(proto_err)
  );

  burst_t iq[$];
  burst_t dq[$];
  int own = 0;          // 0 none, 1 I, 2 D
  int beat = 0;
  int starve = 0;
  bit err_exp = 1'b0;
  bit early = 1'b0;
  bit extra = 1'b0;
  bit drop_i = 1'b0;
  int rdy_pct = 100;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic burst_t mk(input bit is_d, input int len);
    burst_t b;
    b.addr  = {$urandom, $urandom};
    b.len   = LW'(len);
    b.wr    = is_d ? 1'($urandom_range(1)) : 1'b0;
    b.strb  = is_d ? 8'($urandom) : 8'h00;
    b.wbase = is_d ? {$urandom, $urandom} : 64'h0;
    return b;
  endfunction

  task automatic zero_inputs();
    bus.i_valid = 0; bus.i_addr = 0; bus.i_len = 0;
    bus.d_valid = 0; bus.d_is_write = 0; bus.d_addr = 0; bus.d_len = 0;
    bus.d_strobe = 0; bus.d_wdata = 0;
    bus.o_ready = 0; bus.o_last = 0; bus.o_rdata = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {57'h0, bus.o_valid, bus.o_is_write, bus.i_ready, bus.i_last,
                        bus.d_ready, bus.d_last, proto_err}, 64'h0);
    chk({tag, "_addr"}, bus.o_addr, 64'h0);
    chk({tag, "_lenstrb"}, {52'h0, bus.o_len, bus.o_strobe}, 64'h0);
    chk({tag, "_wdata"}, bus.o_wdata, 64'h0);
    chk({tag, "_rdata"}, bus.i_rdata | bus.d_rdata, 64'h0);
  endtask

  task automatic model_clear();
    iq.delete(); dq.delete();
    own = 0; beat = 0; starve = 0; err_exp = 0;
    early = 0; extra = 0; drop_i = 0;
  endtask

  function automatic void decide();
    bit iv, dv;
    iv = iq.size() > 0;
    dv = dq.size() > 0;
    beat = 0;
    if (dv && !(iv && starve == SM)) begin
      own = 2;
      starve = iv ? ((starve < SM) ? starve + 1 : SM) : 0;
    end else if (iv) begin
      own = 1;
      starve = 0;
    end else begin
      own = 0;
    end
  endfunction

  task automatic cycle();
    burst_t ci, cd, cur;
    bit rdy, last, iv, dv, vown;
    int tgt;
    logic [DW-1:0] rd;
    @(posedge clk);
    #1;
    ci = '{default: '0};
    cd = '{default: '0};
    if (iq.size() > 0) ci = iq[0];
    if (dq.size() > 0) cd = dq[0];
    cur = (own == 1) ? ci : cd;
    rdy = 0; last = 0;
    if (own != 0) begin
      rdy = ($urandom_range(99) < rdy_pct);
      tgt = early ? 1 : int'(cur.len) + int'(extra);
      last = rdy && (beat == tgt);
    end
    iv = (own == 1) ? (last ? (iq.size() > 1) : !drop_i) : (iq.size() > 0);
    dv = (own == 2) ? (last ? (dq.size() > 1) : 1'b1) : (dq.size() > 0);
    rd = {$urandom, $urandom};
    bus.i_valid = iv; bus.i_addr = ci.addr; bus.i_len = ci.len;
    bus.d_valid = dv; bus.d_is_write = cd.wr; bus.d_addr = cd.addr; bus.d_len = cd.len;
    bus.d_strobe = cd.strb;
    bus.d_wdata = cd.wbase + ((own == 2) ? 64'(beat) : 64'h0);
    bus.o_ready = rdy; bus.o_last = last; bus.o_rdata = rd;
    #4;
    if (own == 0) begin
      chk("idle_o_valid", bus.o_valid, 0);
      chk("idle_o_addr", bus.o_addr, 0);
      chk("idle_resp", {bus.i_ready, bus.d_ready, bus.i_last, bus.d_last}, 0);
      chk("idle_rdata", bus.i_rdata | bus.d_rdata, 0);
    end else if (own == 1) begin
      chk("gi_o_valid", bus.o_valid, 1);
      chk("gi_o_addr", bus.o_addr, ci.addr);
      chk("gi_o_len", bus.o_len, ci.len);
      chk("gi_wr_strb_wdata", {bus.o_is_write, bus.o_strobe} | bus.o_wdata, 0);
      chk("gi_i_ready_last", {bus.i_ready, bus.i_last}, {rdy, last});
      chk("gi_i_rdata", bus.i_rdata, rd);
      chk("gi_d_quiet", {bus.d_ready, bus.d_last}, 0);
      chk("gi_d_rdata", bus.d_rdata, 0);
    end else begin
      chk("gd_o_valid", bus.o_valid, 1);
      chk("gd_o_addr", bus.o_addr, cd.addr);
      chk("gd_o_len", bus.o_len, cd.len);
      chk("gd_o_wr", bus.o_is_write, cd.wr);
      chk("gd_o_strobe", bus.o_strobe, cd.strb);
      chk("gd_o_wdata", bus.o_wdata, cd.wbase + 64'(beat));
      chk("gd_d_ready_last", {bus.d_ready, bus.d_last}, {rdy, last});
      chk("gd_d_rdata", bus.d_rdata, rd);
      chk("gd_i_quiet", {bus.i_ready, bus.i_last}, 0);
      chk("gd_i_rdata", bus.i_rdata, 0);
    end
    chk("proto_err", proto_err, err_exp);
    // Model advance for the coming edge.
    if (own != 0) begin
      vown = (own == 1) ? iv : dv;
      if (!vown && !last) err_exp = 1;
      if (rdy) begin
        if (last) begin
          if (beat != int'(cur.len)) err_exp = 1;
          if (own == 1) void'(iq.pop_front()); else void'(dq.pop_front());
          early = 0; extra = 0; drop_i = 0;
          decide();
        end else begin
          if (beat == int'(cur.len)) err_exp = 1;
          beat++;
        end
      end
    end else begin
      decide();
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((own != 0 || iq.size() > 0 || dq.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 1);
  endtask

  task automatic hard_reset();
    @(posedge clk);
    #2 resetn = 0;
    zero_inputs();
    model_clear();
    @(posedge clk);
    #3 resetn = 1;
  endtask

  initial begin
    burst_t b;
    zero_inputs();
    model_clear();
    resetn = 0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #3 resetn = 1;
    repeat (2) cycle();

    // Single I read of 4 beats.
    rdy_pct = 100;
    iq.push_back(mk(0, 3));
    drain(40);
    repeat (2) cycle();

    // Simultaneous requests: D write wins, I follows without a bubble.
    iq.push_back(mk(0, 1));
    b = mk(1, 0);
    b.wr = 1;
    dq.push_back(b);
    drain(40);

    // Continuous D traffic with I pending: starvation forces an I grant.
    for (int k = 0; k < 7; k++) dq.push_back(mk(1, 0));
    iq.push_back(mk(0, 0));
    iq.push_back(mk(0, 0));
    drain(100);
    cycle();

    // Randomized mixed traffic with bus back-pressure.
    rdy_pct = 70;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(6) == 0) iq.push_back(mk(0, $urandom_range(3)));
      if ($urandom_range(5) == 0) dq.push_back(mk(1, $urandom_range(3)));
      cycle();
    end
    drain(600);
    rdy_pct = 100;

    // Early o_last on beat 2 of a len=3 burst; error is sticky, next grant still works.
    early = 1;
    iq.push_back(mk(0, 3));
    drain(40);
    dq.push_back(mk(1, 1));
    drain(40);
    repeat (2) cycle();

    // Async reset in the middle of a D burst.
    dq.push_back(mk(1, 7));
    repeat (4) cycle();
    @(posedge clk);
    #2 resetn = 0;
    #2 check_zero("async_rst");
    zero_inputs();
    model_clear();
    @(posedge clk);
    #3 resetn = 1;
    iq.push_back(mk(0, 2));
    drain(40);

    // I drops valid mid-burst: grant held until o_last, error flagged.
    drop_i = 1;
    iq.push_back(mk(0, 3));
    drain(40);
    repeat (2) cycle();

    // Beat overrun: o_ready without o_last at the final beat.
    hard_reset();
    extra = 1;
    dq.push_back(mk(1, 1));
    drain(40);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
